// File: rtl/bcd_conv_sched.sv
// Shared double-dabble binary-to-BCD engine with two round-robin requesters.
// One shift step per clock; the result and its owner id are registered on done.

module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bcd_conv_sched #(
  parameter int WIDTH  = 26,
  parameter int DIGITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [WIDTH-1:0]      bin0,
  input  logic                  req1,
  input  logic [WIDTH-1:0]      bin1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  busy,
  output logic                  done,
  output logic                  done_id,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                   state;
  logic [WIDTH-1:0]         sh;
  logic [DIGITS-1:0][3:0]   dig;
  logic [DIGITS-1:0][3:0]   adj;
  logic [CW-1:0]            cnt;
  logic                     lst;
  logic                     owner;
  logic                     pick1;
  logic [4*DIGITS+WIDTH-1:0] cat;
  logic [4*DIGITS+WIDTH-1:0] nxt;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit_adj u_adj (.d(dig[i]), .q(adj[i]));
  end

  // Adjusted digits and operand shift as one long register.
  assign cat = {adj, sh};
  assign nxt = cat << 1;

  // On a tie the requester not granted last wins.
  assign pick1 = req1 & (~req0 | ~lst);
  assign busy  = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sh      <= '0;
      dig     <= '0;
      cnt     <= '0;
      lst     <= 1'b1;
      owner   <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      bcd     <= '0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (req0 | req1) begin
          owner <= pick1;
          lst   <= pick1;
          sh    <= pick1 ? bin1 : bin0;
          dig   <= '0;
          cnt   <= '0;
          gnt0  <= ~pick1;
          gnt1  <= pick1;
          state <= CONV;
        end
        CONV: begin
          {dig, sh} <= nxt;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST) begin
            bcd     <= nxt[4*DIGITS+WIDTH-1:WIDTH];
            done_id <= owner;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench for bcd_conv_sched: latency, boundaries, round-robin,
// busy-time requests, mid-conversion reset and withdrawn requests.

module tb_bcd_conv_sched;
  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [25:0] bin0, bin1;
  logic        gnt0, gnt1, busy, done, done_id;
  logic [31:0] bcd;

  int nvec = 0;
  int nbad = 0;
  int cyc  = 0;

  bcd_conv_sched #(.WIDTH(26), .DIGITS(8)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .bin0(bin0), .req1(req1), .bin1(bin1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .done_id(done_id), .bcd(bcd)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Wait for done within a bound; returns edges waited and whether it came.
  task automatic wait_done(output int n, output logic got);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      got = done;
    end
  endtask

  task automatic run_one(input int who, input logic [25:0] val,
                         input logic [31:0] exp, input string tag);
    int n;
    logic got;
    if (who == 0) begin bin0 = val; req0 = 1'b1; end
    else          begin bin1 = val; req1 = 1'b1; end
    got = 1'b0;
    for (n = 0; n < 40 && !got; n++) begin
      tick();
      got = (who != 0) ? gnt1 : gnt0;
    end
    chk({tag, "_gnt"}, {31'b0, got}, 32'd1);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_done(n, got);
    chk({tag, "_lat"}, n, 32'd26);
    chk({tag, "_bcd"}, bcd, exp);
    chk({tag, "_id"}, {31'b0, done_id}, who);
    tick();
    chk({tag, "_donepulse"}, {31'b0, done}, 32'd0);
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int n, g, k, gcyc, prev;
    logic got, bad;

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; bin0 = '0; bin1 = '0;
    tick(); tick();
    chk("rst_bcd", bcd, 32'h0);
    chk("rst_flags", {27'b0, gnt0, gnt1, busy, done, done_id}, 32'h0);
    reset = 1'b0;
    tick();

    run_one(0, 26'd12345678, 32'h12345678, "single");
    run_one(1, 26'd67108863, 32'h67108863, "allones");
    run_one(0, 26'd0,        32'h00000000, "zero");

    // Round-robin from reset: tie goes to 0 first, then alternates.
    reset = 1'b1; #1; reset = 1'b0;
    tick();
    bin0 = 26'd111; bin1 = 26'd222; req0 = 1'b1; req1 = 1'b1;
    prev = 0;
    for (k = 0; k < 4; k++) begin
      got = 1'b0;
      for (n = 0; n < 40 && !got; n++) begin
        tick();
        got = gnt0 | gnt1;
      end
      g = gnt1 ? 1 : 0;
      gcyc = cyc;
      chk($sformatf("rr%0d_gnt", k), {31'b0, got}, 32'd1);
      chk($sformatf("rr%0d_who", k), g, k % 2);
      if (k > 0) chk($sformatf("rr%0d_gap", k), gcyc - prev, 32'd28);
      prev = gcyc;
      if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
      wait_done(n, got);
      chk($sformatf("rr%0d_bcd", k), bcd, (k % 2) ? 32'h222 : 32'h111);
      chk($sformatf("rr%0d_id", k), {31'b0, done_id}, k % 2);
    end
    tick(); tick();

    // Request while busy: req1 raised mid-conversion of requester 0.
    bin0 = 26'd4321; req0 = 1'b1;
    got = 1'b0;
    for (n = 0; n < 40 && !got; n++) begin tick(); got = gnt0; end
    chk("busy_gnt0", {31'b0, got}, 32'd1);
    req0 = 1'b0;
    repeat (5) tick();
    bin1 = 26'd8765; req1 = 1'b1;
    bad = 1'b0; got = 1'b0; n = 0;
    while (!got && n < 40) begin
      tick(); n++;
      got = done;
      if (gnt1) bad = 1'b1;
    end
    chk("busy_nognt1", {31'b0, bad}, 32'd0);
    chk("busy_bcd0", bcd, 32'h4321);
    got = 1'b0; n = 0; bad = 1'b0;
    while (!got && n < 40) begin
      tick(); n++;
      got = gnt1;
      if (bcd !== 32'h4321) bad = 1'b1;
    end
    chk("busy_gnt1_delay", n, 32'd2);
    req1 = 1'b0;
    wait_done(n, got);
    chk("busy_hold", {31'b0, bad}, 32'd0);
    chk("busy_bcd1", bcd, 32'h8765);
    chk("busy_id1", {31'b0, done_id}, 32'd1);
    tick();

    // Reset 10 cycles into a conversion of 9999.
    bin0 = 26'd9999; req0 = 1'b1;
    got = 1'b0;
    for (n = 0; n < 40 && !got; n++) begin tick(); got = gnt0; end
    req0 = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_flags", {29'b0, busy, done, done_id}, 32'h0);
    chk("mid_rst_bcd", bcd, 32'h0);
    tick();
    reset = 1'b0;
    bad = 1'b0;
    repeat (40) begin tick(); if (done || busy) bad = 1'b1; end
    chk("mid_rst_nodone", {31'b0, bad}, 32'd0);
    run_one(1, 26'd4242, 32'h4242, "after_rst");

    // One-cycle req0 pulse while busy must be dropped.
    bin1 = 26'd555; req1 = 1'b1;
    got = 1'b0;
    for (n = 0; n < 40 && !got; n++) begin tick(); got = gnt1; end
    req1 = 1'b0;
    repeat (3) tick();
    bin0 = 26'd777; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    wait_done(n, got);
    chk("wd_bcd", bcd, 32'h555);
    bad = 1'b0;
    repeat (40) begin tick(); if (gnt0 || done || busy) bad = 1'b1; end
    chk("wd_noextra", {31'b0, bad}, 32'd0);
    chk("wd_bcd_hold", bcd, 32'h555);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
